// File: rtl/md_stall_ctrl_pkg.sv
// rtl/md_stall_ctrl_pkg.sv - shared opcode/funct constants and FSM encoding for the MDU stall controller
package md_stall_ctrl_pkg;

  localparam logic [5:0] SPECIAL = 6'b000000;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_stall_ctrl_if.sv
// rtl/md_stall_ctrl_if.sv - pipeline-side signal bundle of the MDU stall controller
interface md_stall_ctrl_if;

  logic [31:0] Instr_D;
  logic [31:0] Instr_E;
  logic        IntReq;
  logic        ExcReq;
  logic        mdu_busy;
  logic        md_start;
  logic        md_busy_exp;
  logic        stall_D;
  logic        proto_err;

  // pipeline / MDU side
  modport master (
    output Instr_D, Instr_E, IntReq, ExcReq, mdu_busy,
    input  md_start, md_busy_exp, stall_D, proto_err
  );

  // controller side
  modport slave (
    input  Instr_D, Instr_E, IntReq, ExcReq, mdu_busy,
    output md_start, md_busy_exp, stall_D, proto_err
  );

endinterface

// File: rtl/md_stall_ctrl_class_dec.sv
// rtl/md_stall_ctrl_class_dec.sv - classifies an instruction as MDU start / divide / HI-LO access
module md_class_dec
  import md_stall_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_start,
  output logic        is_div,
  output logic        is_hilo
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       special;
  logic       unused_fields;

  assign opcode  = instr[31:26];
  assign funct   = instr[5:0];
  assign special = (opcode == SPECIAL);

  // register fields play no part in the class decision
  assign unused_fields = ^instr[25:6];

  // mthi/mtlo touch HI/LO but never launch the MDU
  always_comb begin
    is_start = 1'b0;
    is_div   = 1'b0;
    is_hilo  = 1'b0;
    if (special) begin
      is_start = (funct == F_MULT) || (funct == F_MULTU) ||
                 (funct == F_DIV)  || (funct == F_DIVU);
      is_div   = (funct == F_DIV)  || (funct == F_DIVU);
      is_hilo  = is_start ||
                 (funct == F_MFHI) || (funct == F_MTHI) ||
                 (funct == F_MFLO) || (funct == F_MTLO);
    end
  end

endmodule

// File: rtl/md_stall_ctrl.sv
// rtl/md_stall_ctrl.sv - MDU start strobe, latency tracking, D-stage stall and busy cross-check
module md_stall_ctrl
  import md_stall_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic                clk,
  input  logic                reset,
  md_stall_ctrl_if.slave      bus
);

  localparam logic [3:0] MULT_LD = 4'(MULT_LAT - 1);
  localparam logic [3:0] DIV_LD  = 4'(DIV_LAT - 1);

  md_state_e  state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       perr, perr_n;

  logic e_start, e_div, e_hilo_unused;
  logic d_hilo, d_start_unused, d_div_unused;

  md_class_dec u_dec_e (
    .instr    (bus.Instr_E),
    .is_start (e_start),
    .is_div   (e_div),
    .is_hilo  (e_hilo_unused)
  );

  md_class_dec u_dec_d (
    .instr    (bus.Instr_D),
    .is_start (d_start_unused),
    .is_div   (d_div_unused),
    .is_hilo  (d_hilo)
  );

  // interrupts and exceptions suppress the launch but not an operation already running
  assign bus.md_start    = e_start & ~bus.IntReq & ~bus.ExcReq;
  assign bus.md_busy_exp = (state != ST_IDLE);
  assign bus.stall_D     = d_hilo & (bus.md_start | bus.md_busy_exp | bus.mdu_busy);
  assign bus.proto_err   = perr;

  // state, latency counter and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      perr  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      perr  <= perr_n;
    end
  end

  // next state: a new start always wins, reloading even if the previous op is unfinished
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    perr_n  = perr;
    if (bus.mdu_busy != bus.md_busy_exp) begin
      perr_n = 1'b1;
    end
    if (bus.md_start) begin
      if (state != ST_IDLE) begin
        perr_n = 1'b1;
      end
      state_n = e_div ? ST_DIV : ST_MULT;
      cnt_n   = e_div ? DIV_LD : MULT_LD;
    end else if (state != ST_IDLE) begin
      if (cnt == 4'd0) begin
        state_n = ST_IDLE;
      end else begin
        cnt_n = cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_md_stall_ctrl.sv
// tb/tb_md_stall_ctrl.sv - scoreboard bench for md_stall_ctrl against a cycle-count reference model
module tb_md_stall_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic clk;
  logic reset;

  md_stall_ctrl_if bus ();

  md_stall_ctrl #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic st;
    logic bz;
    logic sl;
    logic pe;
  } exp_t;

  exp_t q[$];

  int total = 0;
  int bad   = 0;

  // reference model: remaining busy cycles, environment MDU, sticky error
  int   rem        = 0;
  int   mdu_rem    = 0;
  logic perr       = 1'b0;
  logic drop_armed = 1'b0;

  int stall_seen = 0;
  int start_seen = 0;
  int busy_seen  = 0;

  function automatic void chk(string name, int act, int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endfunction

  function automatic logic is_start(logic [31:0] i);
    int f;
    f = int'(i[5:0]);
    return (i[31:26] == 6'd0) && (f >= 24) && (f <= 27);
  endfunction

  function automatic logic is_div(logic [31:0] i);
    int f;
    f = int'(i[5:0]);
    return (i[31:26] == 6'd0) && (f == 26 || f == 27);
  endfunction

  function automatic logic is_hilo(logic [31:0] i);
    int f;
    f = int'(i[5:0]);
    return is_start(i) || ((i[31:26] == 6'd0) && (f >= 16) && (f <= 19));
  endfunction

  function automatic logic [31:0] mk(int op, int fn);
    logic [31:0] r;
    logic [5:0]  o;
    logic [5:0]  f;
    r = $urandom();
    o = 6'(op);
    f = 6'(fn);
    return {o, r[19:0], f};
  endfunction

  function automatic logic [31:0] rand_instr();
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0: return mk(0, 24);
      1: return mk(0, 25);
      2: return mk(0, 26);
      3: return mk(0, 27);
      4: return mk(0, 16);
      5: return mk(0, 17);
      6: return mk(0, 18);
      7: return mk(0, 19);
      8: return mk(0, 33);
      default: return mk($urandom_range(1, 63), $urandom_range(16, 27));
    endcase
  endfunction

  // drive one cycle at posedge+1, queue its expectation, advance the model at the next edge
  task automatic step(input logic [31:0] d, input logic [31:0] e,
                      input logic ir, input logic xr, input logic rs, input logic dr,
                      output logic stall_o);
    logic mb, es, eb, esl;
    bus.Instr_D = d;
    bus.Instr_E = e;
    bus.IntReq  = ir;
    bus.ExcReq  = xr;
    reset       = rs;
    mb  = (mdu_rem > 0) && !(drop_armed && mdu_rem == 1);
    bus.mdu_busy = mb;
    es  = is_start(e) && !ir && !xr;
    eb  = (rem > 0);
    esl = is_hilo(d) && (es || eb || mb);
    q.push_back('{es, eb, esl, perr});
    stall_o = esl;
    @(posedge clk);
    if (rs) begin
      rem = 0; mdu_rem = 0; perr = 1'b0; drop_armed = 1'b0;
    end else begin
      if (mb != eb) perr = 1'b1;
      if (es) begin
        if (rem > 0) perr = 1'b1;
        rem        = is_div(e) ? DIV_LAT : MULT_LAT;
        mdu_rem    = rem;
        drop_armed = dr;
      end else begin
        if (rem > 0) rem--;
        if (mdu_rem > 0) mdu_rem--;
      end
    end
    #1;
  endtask

  // monitor: compare every presented cycle against the queued expectation
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk("md_start",    int'(bus.md_start),    int'(x.st));
      chk("md_busy_exp", int'(bus.md_busy_exp), int'(x.bz));
      chk("stall_D",     int'(bus.stall_D),     int'(x.sl));
      chk("proto_err",   int'(bus.proto_err),   int'(x.pe));
      if (bus.stall_D === 1'b1) stall_seen++;
      if (bus.md_start === 1'b1) start_seen++;
      if (bus.md_busy_exp === 1'b1) busy_seen++;
    end
  end

  initial begin
    logic        s;
    logic [31:0] pd, pe, nw;
    int          s0, t0, b0;
    logic        ir, xr, rs, dr;

    reset        = 1'b1;
    bus.Instr_D  = 32'd0;
    bus.Instr_E  = 32'd0;
    bus.IntReq   = 1'b0;
    bus.ExcReq   = 1'b0;
    bus.mdu_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step(0, 0, 0, 0, 1, 0, s);
    step(0, 0, 0, 0, 0, 0, s);

    // mult in E, mflo in D
    s0 = stall_seen; t0 = start_seen; b0 = busy_seen;
    step(mk(0, 18), mk(0, 24), 0, 0, 0, 0, s);
    repeat (6) step(mk(0, 18), 0, 0, 0, 0, 0, s);
    chk("mult_stall_cycles", stall_seen - s0, 6);
    chk("mult_start_cycles", start_seen - t0, 1);
    chk("mult_busy_cycles",  busy_seen - b0, 5);
    chk("mult_perr",         int'(bus.proto_err), 0);

    // divu in E, mthi in D
    s0 = stall_seen; b0 = busy_seen;
    step(mk(0, 17), mk(0, 27), 0, 0, 0, 0, s);
    repeat (11) step(mk(0, 17), 0, 0, 0, 0, 0, s);
    chk("divu_stall_cycles", stall_seen - s0, 11);
    chk("divu_busy_cycles",  busy_seen - b0, 10);

    // mult gated by IntReq, then by ExcReq
    s0 = stall_seen; t0 = start_seen;
    step(mk(0, 18), mk(0, 24), 1, 0, 0, 0, s);
    step(mk(0, 16), mk(0, 25), 0, 1, 0, 0, s);
    step(mk(0, 18), 0, 0, 0, 0, 0, s);
    chk("int_start_cycles", start_seen - t0, 0);
    chk("int_stall_cycles", stall_seen - s0, 0);
    chk("int_busy_exp",     int'(bus.md_busy_exp), 0);

    // addu in D while a div is busy
    s0 = stall_seen;
    step(0, mk(0, 26), 0, 0, 0, 0, s);
    repeat (10) step(mk(0, 33), 0, 0, 0, 0, 0, s);
    chk("addu_stall_cycles", stall_seen - s0, 0);

    // MDU drops busy one cycle early on a div
    step(0, mk(0, 26), 0, 0, 0, 1, s);
    repeat (30) step(0, 0, 0, 0, 0, 0, s);
    chk("perr_sticky", int'(bus.proto_err), 1);
    step(0, 0, 0, 0, 1, 0, s);
    chk("perr_cleared", int'(bus.proto_err), 0);

    // reset while a mult is at cnt = 2
    step(0, mk(0, 24), 0, 0, 0, 0, s);
    repeat (2) step(0, 0, 0, 0, 0, 0, s);
    step(0, 0, 0, 0, 1, 0, s);
    chk("rst_busy_exp", int'(bus.md_busy_exp), 0);
    chk("rst_perr",     int'(bus.proto_err), 0);
    step(0, 0, 0, 0, 0, 0, s);

    // randomized pipeline flow: stalls hold D and bubble E
    pd = 0; pe = 0;
    for (int n = 0; n < 2000; n++) begin
      ir = ($urandom_range(0, 7) == 0);
      xr = ($urandom_range(0, 11) == 0);
      rs = ($urandom_range(0, 199) == 0);
      dr = ($urandom_range(0, 9) == 0);
      nw = rand_instr();
      step(pd, pe, ir, xr, rs, dr, s);
      if (rs) begin
        pd = 0; pe = 0;
      end else if (s) begin
        pe = 0;
      end else begin
        pe = pd; pd = nw;
      end
    end

    for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_stall_ctrl.md
# md_stall_ctrl

Initiator-side controller for the multiply/divide unit (MDU) in the 5-stage pipeline. It decodes E-stage instructions to drive the MDU start strobe, gating the strobe with interrupt and exception requests. It tracks each operation's latency with its own counter and generates the D-stage stall for HI/LO-class instructions. It also cross-checks the MDU's `busy` output against the expected occupancy and latches any protocol mismatch.

## Interface
Parameters:
- `MULT_LAT`, default 5: busy cycles after a mult/multu start.
- `DIV_LAT`, default 10: busy cycles after a div/divu start.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`, input, 1: the single clock.
- `reset`, input, 1: synchronous, active-high.
- `Instr_D`, input, 32: instruction in the D stage.
- `Instr_E`, input, 32: instruction in the E stage.
- `IntReq`, input, 1: interrupt taken this cycle.
- `ExcReq`, input, 1: exception taken this cycle.
- `mdu_busy`, input, 1: `busy` output of the MDU.
- `md_start`, output, 1: start strobe to the MDU (combinational).
- `md_busy_exp`, output, 1: expected MDU busy state (registered).
- `stall_D`, output, 1: freeze PC and the D register, and flush E (combinational).
- `proto_err`, output, 1: sticky mismatch flag (registered).

## Operation
- **Decode.** An instruction is SPECIAL when opcode = 000000.
  - START class, by funct: mult 011000, multu 011001, div 011010, divu 011011.
  - HILO class: START class plus mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
- **Start strobe.**
  - `md_start` = (Instr_E is START class) & !IntReq & !ExcReq.
  - mthi/mtlo never assert `md_start`.
- **FSM states:** IDLE, MULT, DIV. A 4-bit down-counter `cnt` runs alongside.
  - IDLE with `md_start` for mult/multu: go to MULT, load `cnt` = MULT_LAT−1.
  - IDLE with `md_start` for div/divu: go to DIV, load `cnt` = DIV_LAT−1.
  - MULT or DIV with `cnt` = 0: go to IDLE.
  - MULT or DIV with `cnt` ≠ 0: decrement `cnt`.
  - `md_start` while not IDLE: set `proto_err` and reload the counter and state for the new operation.
- **Expected busy.** `md_busy_exp` = (state ≠ IDLE).
- **Stall.** `stall_D` = (Instr_D is HILO class) & (`md_start` | `md_busy_exp` | `mdu_busy`).
- **Cross-check.** Each cycle, if `mdu_busy` ≠ `md_busy_exp`, set `proto_err`. It stays set until reset.
- **IntReq/ExcReq** do not cancel an operation already in flight. The counter keeps running, matching the MDU.

## Timing
- **Reset values:** state IDLE, `cnt` = 0, `md_busy_exp` = 0, `proto_err` = 0.
  - `md_start` and `stall_D` then follow their inputs combinationally.
- **Occupancy.** With a start on edge k, `md_busy_exp` is high for exactly LAT cycles, edges k+1 through k+LAT.
  - It falls in the same cycle the MDU drops `busy`.
- **Stall window.** A HILO-class instruction in D stalls during the start cycle and all LAT busy cycles.
  - It advances on the first cycle with `md_busy_exp` = 0.
- **Back-to-back.** A START op in D behind a START op in E stalls. A second `md_start` therefore never arrives within LAT cycles in legal flow.
- **Start with IntReq or ExcReq** in the same cycle: no strobe, state stays IDLE, no stall is induced by it.
- **Reset mid-operation:** return to IDLE immediately at the reset edge. `proto_err` clears.
- **Non-SPECIAL opcodes** and unlisted funct codes are neither START nor HILO class.

## Structure
- A shared package, or the existing define file, holds:
  - opcode/funct constants SPECIAL, F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MTHI, F_MFLO, F_MTLO;
  - the FSM state encoding.
- One sub-module, `md_class_dec`, is natural: it decodes a 32-bit instruction into `is_start`, `is_div`, `is_hilo`.
  - It is instantiated twice, once for Instr_D and once for Instr_E.

## Test plan
- **Mult in E, mflo in D, with a model MDU** (MULT_LAT = 5):
  - `md_start` is 1 for one cycle.
  - `stall_D` is 1 for 6 cycles and mflo issues on cycle 7.
  - `md_busy_exp` is high for 5 cycles; `proto_err` = 0.
- **Divu in E, mthi in D:**
  - `stall_D` is high for 11 cycles.
  - FSM goes IDLE → DIV → IDLE after 10 busy cycles.
- **Mult in E with IntReq = 1:**
  - `md_start` = 0, state stays IDLE.
  - A HILO instruction in D is not stalled by it.
- **Model MDU drops `busy` one cycle early on a div:**
  - `proto_err` rises that cycle and stays 1 through 20 further cycles.
  - Only `reset` clears it.
- **Reset asserted at `cnt` = 2 during a mult:**
  - Next cycle: state IDLE, `md_busy_exp` = 0, `proto_err` = 0.
- **Addu in D while a div is busy:**
  - `stall_D` = 0 throughout.
